// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: registered pad drive/OE per mode, synchronised and
// debounced pad input, sticky rise/fall edge interrupt flags.
module gpio_pad_ctrl #(
  parameter int NUM_GPIO        = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W =
    (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_GPIO-1:0]   gpio_out_i,
  input  logic [NUM_GPIO-1:0]   gpio_dir_i,
  input  logic [2*NUM_GPIO-1:0] pad_mode_i,
  input  logic [NUM_GPIO-1:0]   pad_i,
  output logic [NUM_GPIO-1:0]   pad_o,
  output logic [NUM_GPIO-1:0]   pad_oe_o,
  output logic [NUM_GPIO-1:0]   gpio_in_o,
  input  logic [NUM_GPIO-1:0]   irq_rise_en_i,
  input  logic [NUM_GPIO-1:0]   irq_fall_en_i,
  input  logic [NUM_GPIO-1:0]   irq_clr_i,
  output logic [NUM_GPIO-1:0]   irq_status_o,
  output logic                  irq_o
);

  logic [NUM_GPIO-1:0] pad_d, pad_q;
  logic [NUM_GPIO-1:0] oe_d, oe_q;
  logic [NUM_GPIO-1:0] sync_q [SYNC_STAGES];
  logic [NUM_GPIO-1:0] sync_n;
  logic [NUM_GPIO-1:0] in_d, in_q;
  logic [NUM_GPIO-1:0] prev_q;
  logic [NUM_GPIO-1:0] stat_d, stat_q;
  logic                irq_q;

  always_comb begin
    pad_d = '0;
    oe_d  = '0;
    for (int i = 0; i < NUM_GPIO; i++) begin
      unique case (1'b1)
        pad_mode_i[2*i+:2] == 2'b01: begin
          pad_d[i] = 1'b0;
          oe_d[i]  = gpio_dir_i[i] & ~gpio_out_i[i];
        end
        pad_mode_i[2*i+:2] == 2'b10: begin
          pad_d[i] = gpio_out_i[i];
          oe_d[i]  = 1'b0;
        end
        default: begin
          pad_d[i] = gpio_out_i[i];
          oe_d[i]  = gpio_dir_i[i];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_q <= '0;
      oe_q  <= '0;
    end else begin
      pad_q <= pad_d;
      oe_q  <= oe_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pad_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_n = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
    assign in_d = sync_n;
  end else begin : g_deb
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [CNT_W-1:0] cnt_d [NUM_GPIO];
    logic [CNT_W-1:0] cnt_q [NUM_GPIO];

    // Counter tops out at CNT_MAX, where it either commits or clears.
    always_comb begin
      in_d = in_q;
      for (int i = 0; i < NUM_GPIO; i++) begin
        cnt_d[i] = '0;
        if (sync_n[i] != in_q[i]) begin
          if (cnt_q[i] == CNT_MAX) in_d[i] = sync_n[i];
          else cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < NUM_GPIO; i++) cnt_q[i] <= '0;
      end else begin
        for (int i = 0; i < NUM_GPIO; i++) cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Set has priority over a same-cycle clear.
  assign stat_d = (stat_q & ~irq_clr_i)
                | (in_q & ~prev_q & irq_rise_en_i)
                | (~in_q & prev_q & irq_fall_en_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q   <= '0;
      prev_q <= '0;
      stat_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      in_q   <= in_d;
      prev_q <= in_q;
      stat_q <= stat_d;
      irq_q  <= |stat_q;
    end
  end

  assign pad_o        = pad_q;
  assign pad_oe_o     = oe_q;
  assign gpio_in_o    = in_q;
  assign irq_status_o = stat_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb_gpio_pad_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-history reference model.
module tb_gpio_pad_ctrl;
  localparam int NG = 32;
  localparam int SY = 2;
  localparam int DB = 4;
  localparam int HLEN = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NG-1:0] gpio_out, gpio_dir, pad_i;
  logic [NG-1:0] rise_en, fall_en, clr;
  logic [2*NG-1:0] pad_mode;
  logic [NG-1:0] pad_o, pad_oe, gpio_in, stat;
  logic irq;

  logic [7:0] pad2, z8, p2_pad_o, p2_oe, p2_in, p2_stat;
  logic [15:0] z16;
  logic p2_irq;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  gpio_pad_ctrl #(.NUM_GPIO(NG), .SYNC_STAGES(SY), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n),
    .gpio_out_i(gpio_out), .gpio_dir_i(gpio_dir),
    .pad_mode_i(pad_mode), .pad_i(pad_i),
    .pad_o(pad_o), .pad_oe_o(pad_oe), .gpio_in_o(gpio_in),
    .irq_rise_en_i(rise_en), .irq_fall_en_i(fall_en),
    .irq_clr_i(clr), .irq_status_o(stat), .irq_o(irq)
  );

  gpio_pad_ctrl #(.NUM_GPIO(8), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(0)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .gpio_out_i(z8), .gpio_dir_i(z8),
    .pad_mode_i(z16), .pad_i(pad2),
    .pad_o(p2_pad_o), .pad_oe_o(p2_oe), .gpio_in_o(p2_in),
    .irq_rise_en_i(z8), .irq_fall_en_i(z8),
    .irq_clr_i(z8), .irq_status_o(p2_stat), .irq_o(p2_irq)
  );

  // Reference model: pad history by cycle index, run-length debounce.
  logic [NG-1:0] m_hist [HLEN];
  int m_cyc;
  int m_run [NG];
  logic [NG-1:0] m_in, m_prev, m_stat, m_pad_o, m_oe;
  logic m_irq;
  logic [NG-1:0] t_s, t_nin, t_po, t_oe;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc <= 0;
      m_in <= '0;
      m_prev <= '0;
      m_stat <= '0;
      m_irq <= 1'b0;
      m_pad_o <= '0;
      m_oe <= '0;
      for (int i = 0; i < NG; i++) m_run[i] <= 0;
    end else begin
      t_s = (m_cyc >= SY) ? m_hist[(m_cyc - SY) % HLEN] : '0;
      t_nin = m_in;
      for (int i = 0; i < NG; i++) begin
        case (pad_mode[2*i+:2])
          2'b01: begin t_po[i] = 1'b0; t_oe[i] = gpio_dir[i] & ~gpio_out[i]; end
          2'b10: begin t_po[i] = gpio_out[i]; t_oe[i] = 1'b0; end
          default: begin t_po[i] = gpio_out[i]; t_oe[i] = gpio_dir[i]; end
        endcase
        if (t_s[i] != m_in[i]) begin
          if (m_run[i] + 1 == DB) begin
            t_nin[i] = t_s[i];
            m_run[i] <= 0;
          end else begin
            m_run[i] <= m_run[i] + 1;
          end
        end else begin
          m_run[i] <= 0;
        end
      end
      m_hist[m_cyc % HLEN] <= pad_i;
      m_cyc <= m_cyc + 1;
      m_pad_o <= t_po;
      m_oe <= t_oe;
      m_stat <= (m_stat & ~clr) | (m_in & ~m_prev & rise_en)
              | (~m_in & m_prev & fall_en);
      m_prev <= m_in;
      m_in <= t_nin;
      m_irq <= |m_stat;
    end
  end

  task automatic test_reset;
    rst_n = 1'b0;
    pad_i = '1;
    repeat (3) @(negedge clk);
    total++; if (pad_oe !== '0) begin bad++; $display("FAIL rst_oe got=%h want=0", pad_oe); end
    total++; if (pad_o !== '0) begin bad++; $display("FAIL rst_pad_o got=%h want=0", pad_o); end
    total++; if (gpio_in !== '0) begin bad++; $display("FAIL rst_in got=%h want=0", gpio_in); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b want=0", irq); end
    total++; if (stat !== '0) begin bad++; $display("FAIL rst_stat got=%h want=0", stat); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (gpio_in !== '0) begin bad++; $display("FAIL rst_lat5 got=%h want=0", gpio_in); end
    @(negedge clk);
    total++; if (gpio_in !== '1) begin bad++; $display("FAIL rst_lat6 got=%h want=ffffffff", gpio_in); end
    pad_i = '0;
    repeat (12) @(negedge clk);
    total++; if (gpio_in !== '0) begin bad++; $display("FAIL rst_settle got=%h want=0", gpio_in); end
  endtask

  task automatic test_output;
    pad_mode[7:6] = 2'b00; gpio_dir[3] = 1'b1; gpio_out[3] = 1'b1;
    @(negedge clk);
    total++; if (pad_oe[3] !== 1'b1) begin bad++; $display("FAIL pp_oe got=%b want=1", pad_oe[3]); end
    total++; if (pad_o[3] !== 1'b1) begin bad++; $display("FAIL pp_o got=%b want=1", pad_o[3]); end
    pad_mode[7:6] = 2'b01;
    @(negedge clk);
    total++; if (pad_oe[3] !== 1'b0) begin bad++; $display("FAIL od_rel_oe got=%b want=0", pad_oe[3]); end
    gpio_out[3] = 1'b0;
    @(negedge clk);
    total++; if (pad_oe[3] !== 1'b1) begin bad++; $display("FAIL od_low_oe got=%b want=1", pad_oe[3]); end
    total++; if (pad_o[3] !== 1'b0) begin bad++; $display("FAIL od_low_o got=%b want=0", pad_o[3]); end
    pad_mode[7:6] = 2'b10; gpio_out[3] = 1'b1;
    @(negedge clk);
    total++; if (pad_oe[3] !== 1'b0) begin bad++; $display("FAIL fin_oe got=%b want=0", pad_oe[3]); end
    total++; if (pad_o[3] !== 1'b1) begin bad++; $display("FAIL fin_o got=%b want=1", pad_o[3]); end
    pad_mode[7:6] = 2'b11; gpio_out[3] = 1'b0;
    @(negedge clk);
    total++; if (pad_oe[3] !== 1'b1 || pad_o[3] !== 1'b0) begin
      bad++; $display("FAIL rsv_mode got=%b%b want=10", pad_oe[3], pad_o[3]); end
    pad_mode = '0; gpio_dir = '0; gpio_out = '0;
  endtask

  task automatic test_debounce;
    pad_i[5] = 1'b1;
    repeat (3) @(negedge clk);
    pad_i[5] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      total++; if (gpio_in[5] !== 1'b0 || stat[5] !== 1'b0) begin
        bad++; $display("FAIL glitch k=%0d got=%b%b want=00", k, gpio_in[5], stat[5]); end
    end
    pad_i[5] = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (gpio_in[5] !== 1'b0) begin bad++; $display("FAIL deb_e5 got=%b want=0", gpio_in[5]); end
    pad_i[5] = 1'b0;
    @(negedge clk);
    total++; if (gpio_in[5] !== 1'b1) begin bad++; $display("FAIL deb_e6 got=%b want=1", gpio_in[5]); end
    repeat (4) @(negedge clk);
    total++; if (gpio_in[5] !== 1'b1) begin bad++; $display("FAIL deb_e10 got=%b want=1", gpio_in[5]); end
    @(negedge clk);
    total++; if (gpio_in[5] !== 1'b0) begin bad++; $display("FAIL deb_e11 got=%b want=0", gpio_in[5]); end
  endtask

  task automatic test_irq_rise;
    int n;
    rise_en[7] = 1'b1; fall_en[7] = 1'b0;
    pad_i[7] = 1'b1;
    n = 0;
    while (gpio_in[7] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (n != 6) begin bad++; $display("FAIL rise_lat got=%0d want=6", n); end
    @(negedge clk);
    total++; if (stat[7] !== 1'b1 || irq !== 1'b0) begin
      bad++; $display("FAIL rise_set got=%b%b want=10", stat[7], irq); end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL rise_irq got=%b want=1", irq); end
    clr[7] = 1'b1;
    @(negedge clk);
    clr[7] = 1'b0;
    total++; if (stat[7] !== 1'b0 || irq !== 1'b1) begin
      bad++; $display("FAIL clr_stat got=%b%b want=01", stat[7], irq); end
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL clr_irq got=%b want=0", irq); end
    pad_i[7] = 1'b0;
    n = 0;
    while (gpio_in[7] !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    total++; if (n != 6) begin bad++; $display("FAIL fall_lat got=%0d want=6", n); end
    repeat (3) begin
      @(negedge clk);
      total++; if (stat[7] !== 1'b0 || irq !== 1'b0) begin
        bad++; $display("FAIL fall_noset got=%b%b want=00", stat[7], irq); end
    end
    rise_en[7] = 1'b0;
  endtask

  task automatic test_set_clr;
    int n;
    rise_en[0] = 1'b1;
    pad_i[0] = 1'b1;
    n = 0;
    while (gpio_in[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (n >= 20) begin bad++; $display("FAIL sc_wait got=timeout want=rise"); end
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    total++; if (stat[0] !== 1'b1) begin bad++; $display("FAIL set_wins got=%b want=1", stat[0]); end
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    total++; if (stat[0] !== 1'b0) begin bad++; $display("FAIL clr_next got=%b want=0", stat[0]); end
    rise_en[0] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nodeb;
    pad2[2] = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (p2_in[2] !== 1'b0) begin bad++; $display("FAIL nodeb_e3 got=%b want=0", p2_in[2]); end
    @(negedge clk);
    total++; if (p2_in[2] !== 1'b1) begin bad++; $display("FAIL nodeb_e4 got=%b want=1", p2_in[2]); end
  endtask

  task automatic test_reset_mid;
    pad_i[9] = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (gpio_in[9] !== 1'b0) begin bad++; $display("FAIL mid_pre got=%b want=0", gpio_in[9]); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (gpio_in !== '0) begin bad++; $display("FAIL mid_rst_in got=%h want=0", gpio_in); end
    total++; if (p2_in !== '0) begin bad++; $display("FAIL mid_rst_in2 got=%h want=0", p2_in); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (gpio_in[9] !== 1'b0) begin bad++; $display("FAIL mid_e5 got=%b want=0", gpio_in[9]); end
    @(negedge clk);
    total++; if (gpio_in[9] !== 1'b1) begin bad++; $display("FAIL mid_e6 got=%b want=1", gpio_in[9]); end
  endtask

  task automatic test_random;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      total++; if (pad_o !== m_pad_o) begin bad++; $display("FAIL rnd_pad_o c=%0d got=%h want=%h", c, pad_o, m_pad_o); end
      total++; if (pad_oe !== m_oe) begin bad++; $display("FAIL rnd_oe c=%0d got=%h want=%h", c, pad_oe, m_oe); end
      total++; if (gpio_in !== m_in) begin bad++; $display("FAIL rnd_in c=%0d got=%h want=%h", c, gpio_in, m_in); end
      total++; if (stat !== m_stat) begin bad++; $display("FAIL rnd_stat c=%0d got=%h want=%h", c, stat, m_stat); end
      total++; if (irq !== m_irq) begin bad++; $display("FAIL rnd_irq c=%0d got=%b want=%b", c, irq, m_irq); end
      gpio_out = $urandom;
      gpio_dir = $urandom;
      pad_mode = {$urandom, $urandom};
      pad_i = pad_i ^ ($urandom & $urandom & $urandom);
      clr = $urandom & $urandom & $urandom & $urandom;
      if ($urandom_range(0, 15) == 0) begin
        rise_en = $urandom;
        fall_en = $urandom;
      end
    end
  endtask

  initial begin
    gpio_out = '0; gpio_dir = '0; pad_mode = '0; pad_i = '0;
    rise_en = '0; fall_en = '0; clr = '0;
    pad2 = '0; z8 = '0; z16 = '0;
    test_reset;
    test_output;
    test_debounce;
    test_irq_rise;
    test_set_clr;
    test_nodeb;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
